// File: rtl/bus_nxd_pkg.sv
// Shared definitions for the bus NXD timer: channel state encoding and default timing constants.
package bus_nxd_pkg;

    typedef enum logic [1:0] {
        CH_IDLE = 2'b00,
        CH_WAIT = 2'b01,
        CH_NXD  = 2'b10
    } chan_state_e;

    localparam int unsigned LATCH_CYCLES_DEF   = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/bus_nxd_chan.sv
// One bus-cycle channel: edge detect, latch pulse stretcher and (with BUS_NXD_TIMEOUT_EN) the ack timeout FSM.
module bus_nxd_chan
    import bus_nxd_pkg::*;
#(
    parameter int unsigned LATCH_CYCLES   = LATCH_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic cycle,
    input  logic ack,
    input  logic clr,
    output logic latch,
    output logic busy,
    output logic nxd
);

    localparam int unsigned LCNT_W = $clog2(LATCH_CYCLES) + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(LATCH_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);

    logic              prev_q;
    logic              rise;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;

    assign rise = cycle & ~prev_q;

    always_comb begin
        lcnt_d = lcnt_q;
        if (rise) begin
            lcnt_d = LCNT_LOAD;
        end else if (lcnt_q != '0) begin
            lcnt_d = lcnt_q - LCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            lcnt_q <= '0;
        end else if (clken) begin
            prev_q <= cycle;
            lcnt_q <= lcnt_d;
        end
    end

    assign latch = (lcnt_q != '0);

`ifdef BUS_NXD_TIMEOUT_EN
    chan_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CH_IDLE;
            tmr_q   <= '1;
        end else if (clken) begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Priority in WAIT: ack, then aborted cycle, then expiry, so ack beats timeout on the same tick.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            CH_IDLE: begin
                if (rise) begin
                    state_d = CH_WAIT;
                    tmr_d   = TMR_LOAD;
                end
            end
            CH_WAIT: begin
                if (ack || !cycle) begin
                    state_d = CH_IDLE;
                end else if (tmr_q == '0) begin
                    state_d = CH_NXD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            CH_NXD: begin
                if (clr && rise) begin
                    state_d = CH_WAIT;
                    tmr_d   = TMR_LOAD;
                end else if (clr) begin
                    state_d = CH_IDLE;
                end
            end
            default: begin
                state_d = CH_IDLE;
            end
        endcase
    end

    assign busy = (state_q == CH_WAIT);
    assign nxd  = (state_q == CH_NXD);
`else
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ack, clr, TMR_LOAD};

    assign busy = 1'b0;
    assign nxd  = 1'b0;
`endif

endmodule

// File: rtl/bus_nxd_timer.sv
// Bus NXD timer top: CHANNELS independent bus_nxd_chan instances plus the registered nxdAny summary.
// Optional ack-timeout/NXD state machines are built only when BUS_NXD_TIMEOUT_EN is defined.
module bus_nxd_timer
    import bus_nxd_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned LATCH_CYCLES   = LATCH_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic [CHANNELS-1:0] cycle,
    input  logic [CHANNELS-1:0] ack,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] latch,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] nxd,
    output logic                nxdAny
);

    logic nxd_any_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        bus_nxd_chan #(
            .LATCH_CYCLES  (LATCH_CYCLES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .clken(clken),
            .cycle(cycle[g]),
            .ack  (ack[g]),
            .clr  (clr[g]),
            .latch(latch[g]),
            .busy (busy[g]),
            .nxd  (nxd[g])
        );
    end

    // Updated every clk regardless of clken so it trails nxd by exactly one clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nxd_any_q <= 1'b0;
        end else begin
            nxd_any_q <= |nxd;
        end
    end

    assign nxdAny = nxd_any_q;

endmodule

// File: tb/tb_bus_nxd_timer.sv
// Self-checking bench for bus_nxd_timer (CHANNELS=2, LATCH_CYCLES=4, TIMEOUT_CYCLES=8) with a scoreboard queue.
module tb_bus_nxd_timer;

    localparam int CH = 2;
    localparam int L  = 4;
    localparam int T  = 8;
`ifdef BUS_NXD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          clken;
    logic [CH-1:0] cycle, ack, clr;
    logic [CH-1:0] latch, busy, nxd;
    logic          nxdAny;

    bus_nxd_timer #(
        .CHANNELS      (CH),
        .LATCH_CYCLES  (L),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clken (clken),
        .cycle (cycle),
        .ack   (ack),
        .clr   (clr),
        .latch (latch),
        .busy  (busy),
        .nxd   (nxd),
        .nxdAny(nxdAny)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] latch;
        logic [CH-1:0] busy;
        logic [CH-1:0] nxd;
        logic          any;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state (0 idle, 1 waiting, 2 nxd)
    int m_prev[CH];
    int m_lcnt[CH];
    int m_st[CH];
    int m_tmr[CH];
    bit m_any;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_prev[i] = 0;
            m_lcnt[i] = 0;
            m_st[i]   = 0;
            m_tmr[i]  = T - 1;
        end
        m_any = 1'b0;
    endfunction

    function automatic exp_t model_tick(input logic ce, input logic [CH-1:0] cy,
                                        input logic [CH-1:0] ak, input logic [CH-1:0] cl);
        exp_t e;
        bit   nxd_before;
        bit   rise;
        if (!rst) begin
            model_reset();
        end else begin
            nxd_before = 1'b0;
            for (int i = 0; i < CH; i++) if (m_st[i] == 2) nxd_before = 1'b1;
            if (ce) begin
                for (int i = 0; i < CH; i++) begin
                    rise = cy[i] && (m_prev[i] == 0);
                    if (rise) m_lcnt[i] = L;
                    else if (m_lcnt[i] > 0) m_lcnt[i]--;
                    if (TO_EN) begin
                        if (m_st[i] == 0) begin
                            if (rise) begin m_st[i] = 1; m_tmr[i] = T - 1; end
                        end else if (m_st[i] == 1) begin
                            if (ak[i]) m_st[i] = 0;
                            else if (!cy[i]) m_st[i] = 0;
                            else if (m_tmr[i] == 0) m_st[i] = 2;
                            else m_tmr[i]--;
                        end else begin
                            if (cl[i] && rise) begin m_st[i] = 1; m_tmr[i] = T - 1; end
                            else if (cl[i]) m_st[i] = 0;
                        end
                    end
                    m_prev[i] = cy[i] ? 1 : 0;
                end
            end
            m_any = nxd_before;
        end
        for (int i = 0; i < CH; i++) begin
            e.latch[i] = (m_lcnt[i] > 0);
            e.busy[i]  = (m_st[i] == 1);
            e.nxd[i]   = (m_st[i] == 2);
        end
        e.any = m_any;
        return e;
    endfunction

    task automatic step(input logic ce, input logic [CH-1:0] cy,
                        input logic [CH-1:0] ak, input logic [CH-1:0] cl);
        exp_t e;
        clken = ce;
        cycle = cy;
        ack   = ak;
        clr   = cl;
        sb.push_back(model_tick(ce, cy, ak, cl));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq("latch",  32'(latch),  32'(e.latch));
            check_eq("busy",   32'(busy),   32'(e.busy));
            check_eq("nxd",    32'(nxd),    32'(e.nxd));
            check_eq("nxdAny", 32'(nxdAny), 32'(e.any));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int cnt1;
        int first;
        logic [CH-1:0] rcy, rak, rcl;
        logic rce;

        rst = 1'b0; clken = 1'b0; cycle = '0; ack = '0; clr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_latch",  32'(latch),  32'd0);
        check_eq("rst_busy",   32'(busy),   32'd0);
        check_eq("rst_nxd",    32'(nxd),    32'd0);
        check_eq("rst_nxdAny", 32'(nxdAny), 32'd0);
        rst = 1'b1;
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);

        // Latch width on channel 0, channel 1 untouched
        cnt = 0; cnt1 = 0;
        for (int k = 0; k < 7; k++) begin
            step(1, 2'b01, 2'b00, 2'b00);
            if (latch[0]) cnt++;
            if (latch[1]) cnt1++;
        end
        check_eq("latch0_width", 32'(cnt), 32'(L));
        check_eq("latch1_quiet", 32'(cnt1), 32'd0);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);

        // Channel 1 acked five ticks after its edge, with a stray clr while waiting
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 2'b10, (k == 5) ? 2'b10 : 2'b00, (k == 2) ? 2'b10 : 2'b00);
            if (busy[1]) cnt++;
        end
        check_eq("busy1_len", 32'(cnt), TO_EN ? 32'd5 : 32'd0);
        step(1, 2'b00, 2'b00, 2'b00);

        // Timeout to NXD on channel 0, then clear
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step(1, 2'b01, 2'b00, 2'b00);
            if (nxd[0] && first < 0) first = k;
        end
        check_eq("nxd_tick", 32'(first), TO_EN ? 32'd8 : 32'hFFFF_FFFF);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b01);
        step(1, 2'b00, 2'b00, 2'b00);

        // Ack on the exact expiry tick
        for (int k = 0; k < 9; k++) step(1, 2'b01, (k == 8) ? 2'b01 : 2'b00, 2'b00);
        step(1, 2'b01, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);

        // Reach NXD, then clr together with a new edge
        for (int k = 0; k < 10; k++) step(1, 2'b10, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b10, 2'b00, 2'b10);
        step(1, 2'b10, 2'b10, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);

        // clken toggling while waiting
        for (int k = 0; k < 22; k++) step(k[0] ? 1'b0 : 1'b1, 2'b10, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b10);

        // Asynchronous reset mid-WAIT, cycle still high at release
        for (int k = 0; k < 3; k++) step(1, 2'b01, 2'b00, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_latch",  32'(latch),  32'd0);
        check_eq("arst_busy",   32'(busy),   32'd0);
        check_eq("arst_nxd",    32'(nxd),    32'd0);
        check_eq("arst_nxdAny", 32'(nxdAny), 32'd0);
        model_reset();
        step(1, 2'b01, 2'b00, 2'b00);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) step(1, 2'b01, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00, 2'b00);

        // Random traffic on both channels
        rcy = '0;
        for (int k = 0; k < 400; k++) begin
            rce = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 5) == 0) rcy[i] = ~rcy[i];
                rak[i] = ($urandom_range(0, 11) == 0);
                rcl[i] = ($urandom_range(0, 7) == 0);
            end
            step(rce, rcy, rak, rcl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_nxd_timer.md
BUS_NXD_TIMER -- requirements
Module: bus_nxd_timer

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent bus-cycle channels (legal range 1..8).
REQ-002 Parameter LATCH_CYCLES, default 4, number of clken ticks each latch output stays high (legal range 1..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 64, number of clken ticks allowed before a missing ack becomes NXD (legal range 2..1024).
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 clken  input  1  clock enable; all state frozen when low.
REQ-007 cycle  input  CHANNELS  per-channel bus-cycle-in-progress level (VMA IO/memory cycle flag).
REQ-008 ack  input  CHANNELS  per-channel target acknowledge, sampled only when clken is high.
REQ-009 clr  input  CHANNELS  per-channel NXD clear, driven by the microcode CLR decode.
REQ-010 latch  output  CHANNELS  per-channel cycle latch pulse (generalised IO latch).
REQ-011 busy  output  CHANNELS  channel is waiting for ack.
REQ-012 nxd  output  CHANNELS  sticky non-existent-device flag.
REQ-013 nxdAny  output  1  OR of all nxd bits, registered.

Function
REQ-014 Each channel SHALL detect a rising edge as cycle high while the stored previous cycle value is low; the previous value SHALL update only on clken ticks.
REQ-015 On an edge, latch SHALL go high on the next clken tick and stay high for exactly LATCH_CYCLES clken ticks; a new edge while latch is high SHALL reload the full count.
REQ-016 Channel states: IDLE, WAIT, NXD; encoding 2 bits from the shared package.
REQ-017 IDLE + edge -> WAIT; timer loaded with TIMEOUT_CYCLES-1; busy=1.
REQ-018 WAIT + ack -> IDLE; busy=0.
REQ-019 WAIT + cycle low without ack -> IDLE (aborted cycle, no NXD).
REQ-020 WAIT + timer at 0 without ack -> NXD; nxd=1, busy=0.
REQ-021 ack and timer expiry on the same tick: ack wins (-> IDLE).
REQ-022 NXD: nxd held until clr; clr -> IDLE; edges in NXD other than under clr SHALL be ignored for state but still update the edge detector.
REQ-023 clr and an edge on the same tick in NXD: go to WAIT with the timer loaded, nxd cleared.
REQ-024 clr in IDLE or WAIT: no effect.
REQ-025 Timer width = clog2(TIMEOUT_CYCLES); latch counter width = clog2(LATCH_CYCLES)+1; counters saturate at 0 and never wrap.
REQ-026 nxdAny SHALL lag nxd by exactly one clk (not clken) cycle.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels never interact.

Reset
REQ-028 When rst is low, all channels go to IDLE; latch, busy, nxd and nxdAny are 0; the previous-cycle register is 0; the latch counter is 0; and the timer is at its maximum.
REQ-029 Reset asserted mid-WAIT or mid-NXD SHALL discard the state with no nxd output; after release, a cycle input already high SHALL be treated as a rising edge.

Configuration
REQ-030 Macro BUS_NXD_TIMEOUT_EN: when defined, REQ-016..REQ-024 apply.
REQ-031 When BUS_NXD_TIMEOUT_EN is undefined, no timer or state machine is built; busy, nxd and nxdAny are tied to 0; clr and ack are ignored; the latch behaviour of REQ-015 is unchanged.

Structure
REQ-032 The shared package bus_nxd_pkg SHALL hold the state encoding and the default LATCH_CYCLES and TIMEOUT_CYCLES constants.
REQ-033 The per-channel logic SHALL be the sub-module bus_nxd_chan, instantiated CHANNELS times by a generate loop; the top level holds only the nxdAny register.

Verification
REQ-034 CHANNELS=2, LATCH_CYCLES=4: rising edge on cycle[0] with clken constant 1 -> latch[0] high for exactly 4 clk; latch[1] stays 0.
REQ-035 Timer at 3 (TIMEOUT_CYCLES=64), ack[1] pulses on the tick of the edge plus 10 -> busy[1] high for 10 ticks then 0; nxd[1] stays 0.
REQ-036 Edge with no ack, TIMEOUT_CYCLES=8 -> nxd goes to 1 on tick 8; nxdAny goes to 1 one clk later; nxd holds until clr pulses, then returns to 0.
REQ-037 ack on the exact expiry tick -> IDLE, nxd=0; clr plus edge on the same tick in NXD -> busy=1, nxd=0.
REQ-038 clken toggling 1/0 during WAIT -> expiry occurs after 8 clken-high ticks, not 8 clk cycles; rst low mid-WAIT -> all outputs 0 immediately (asynchronously).
REQ-039 Build without BUS_NXD_TIMEOUT_EN -> busy, nxd and nxdAny remain 0 under all stimulus; latch timing is identical to REQ-034.
